btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
Conditions the raw push-button inputs from board pins into clean, single-cycle events for the system's btinc/btmode/btsel PIO inputs; sits directly upstream of the system block.
- Per button: 2-flop synchroniser, polarity normalisation, counter-based debounce, press/release pulse generation.
- Optional hold-to-auto-repeat per button, so holding the increment button steps the time setting.

Parameters:
N_BTN, 3, number of buttons; bit 0=inc, 1=mode, 2=sel.
ACTIVE_LOW, 1, 1: raw pin low means pressed; 0: raw pin high means pressed.
DEBOUNCE_CYC, 1000000, cycles the synchronised input must hold a new level before it is accepted (20 ms at 50 MHz); must be >= 2.
HOLD_CYC, 25000000, cycles a button must be held after its press pulse before the first repeat pulse; must be >= 1.
REPEAT_CYC, 5000000, cycles between subsequent repeat pulses; must be >= 1.
REPEAT_EN, 3'b001, per-button auto-repeat enable mask.

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  synchronous, active-high reset
btn_raw  in  N_BTN  asynchronous raw button pins
btn_level  out  N_BTN  debounced level, 1 = pressed
btn_press  out  N_BTN  1-cycle pulse on accepted press
btn_release  out  N_BTN  1-cycle pulse on accepted release
btn_event  out  N_BTN  btn_press OR btn_repeat; this output drives the system button inputs
btn_repeat  out  N_BTN  1-cycle auto-repeat pulse

Behaviour:
- Interface: one clock, clk_clk. Reset is synchronous and active-high (reset_reset), sampled on the rising edge of clk_clk.
- Reset values:
  - All outputs 0.
  - Synchroniser flops hold the released level.
  - Debounced state = released; all counters 0; FSM = IDLE.
- Channels are fully independent; simultaneous activity on several buttons produces simultaneous pulses.
- Synchroniser: two flops on btn_raw, then XOR with ACTIVE_LOW so that 1 = pressed.
- Debounce, per channel:
  - Counter cnt clears whenever sync == stable.
  - Otherwise cnt increments.
  - When sync != stable and cnt == DEBOUNCE_CYC-1: stable toggles, cnt clears.
  - A glitch shorter than DEBOUNCE_CYC cycles produces no output.
- Latency: a raw change sampled at edge 0 and held produces btn_level change and the press/release pulse in the cycle after edge DEBOUNCE_CYC+2 (fixed, exact).
- FSM per channel: states IDLE, HELD, REPEAT.
  - IDLE -> HELD on stable rise. btn_press=1 for that cycle; hold counter hc clears.
  - HELD: hc increments each cycle.
    - If REPEAT_EN[i] and hc == HOLD_CYC-1: btn_repeat=1, go to REPEAT, clear hc.
    - If REPEAT_EN[i]=0: stay in HELD, hc saturates.
  - REPEAT: hc increments; when hc == REPEAT_CYC-1, btn_repeat=1 and hc clears.
  - Any state -> IDLE on stable fall. btn_release=1 for that cycle. No repeat pulse is issued in the release cycle.
- btn_press and btn_repeat are never high in the same cycle, so btn_event is always a single-cycle pulse.
- Reset mid-press: outputs drop to 0 on the reset edge. If the button is still held after reset deasserts, a fresh press pulse fires after the full latency.
- Counter widths: $clog2 of the largest terminal value +1. No wrap-around is reachable, because the terminal compare clears the counter first.

Decomposition:
- Package btn_pkg:
  - FSM state enum (IDLE, HELD, REPEAT).
  - Button index constants BTN_INC=0, BTN_MODE=1, BTN_SEL=2.
- Sub-module btn_channel: one button's synchroniser, debouncer and FSM.
- Top level: a generate loop of N_BTN btn_channel instances; per-channel REPEAT_EN bit passed as a parameter.

Test Plan:
All scenarios use DEBOUNCE_CYC=4, HOLD_CYC=10, REPEAT_CYC=3, ACTIVE_LOW=1.
- Clean press: btn_raw[0] goes 1->0 and is held -> btn_press[0]=1 exactly once, 6 cycles after the sampling edge; btn_level[0]=1 from then on.
- Glitch: btn_raw[1] low for 3 cycles, then high -> no press, release or level change on any output.
- Auto-repeat: hold btn_raw[0] low for 30 cycles -> press at t, repeat at t+10, t+13, t+16, …. Release then gives btn_release[0]=1 once, 6 cycles after raw returns high, with no repeat in that cycle.
- Repeat disabled: hold btn_raw[2] low for 30 cycles -> exactly one btn_press[2] and zero btn_repeat[2] pulses.
- Simultaneous buttons: btn_raw goes 3'b111 -> 3'b000 on one edge -> btn_press=3'b111 in the same cycle.
- Reset mid-hold: assert reset_reset for 1 cycle while button 0 is held in REPEAT -> all outputs 0 the next cycle; a new btn_press[0] follows 6 cycles after reset deasserts.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioner.
// Button indices match the bit positions of the btn_* buses.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_e;

  localparam int BTN_INC  = 0;
  localparam int BTN_MODE = 1;
  localparam int BTN_SEL  = 2;

endpackage : btn_pkg

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, polarity normalisation, counter debounce,
// and an IDLE/HELD/REPEAT FSM producing registered level and event pulses.
module btn_channel
  import btn_pkg::*;
#(
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned HOLD_CYC     = 25000000,
  parameter int unsigned REPEAT_CYC   = 5000000,
  parameter bit          REPEAT_EN    = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int unsigned HC_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int          CNT_W  = $clog2(DEBOUNCE_CYC) + 1;
  localparam int          HC_W   = $clog2(HC_MAX) + 1;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYC - 1);
  localparam logic [HC_W-1:0]  REP_LAST  = HC_W'(REPEAT_CYC - 1);

  logic             sync1_q, sync2_q, sync_n;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  btn_state_e       state_q, state_d;
  logic [HC_W-1:0]  hc_q, hc_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;

  assign sync_n = sync2_q ^ ACTIVE_LOW;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync_n == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == DEB_LAST) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    hc_d      = hc_q;
    level_d   = stable_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (stable_q) begin
          state_d = ST_HELD;
          press_d = 1'b1;
          hc_d    = '0;
        end
      end
      ST_HELD: begin
        if (!stable_q) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          hc_d      = '0;
        end else if (hc_q == HOLD_LAST) begin
          // Without auto-repeat the hold counter simply parks at its terminal value.
          if (REPEAT_EN) begin
            state_d  = ST_REPEAT;
            repeat_d = 1'b1;
            hc_d     = '0;
          end
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!stable_q) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          hc_d      = '0;
        end else if (hc_q == REP_LAST) begin
          repeat_d = 1'b1;
          hc_d     = '0;
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= ACTIVE_LOW;
      sync2_q   <= ACTIVE_LOW;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      state_q   <= ST_IDLE;
      hc_q      <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      hc_q      <= hc_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule : btn_channel

// File: rtl/btn_conditioner.sv
// Conditions N_BTN raw push-button pins into debounced levels and single-cycle
// press/release/repeat events; btn_event feeds the system button inputs.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int          N_BTN        = 3,
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned HOLD_CYC     = 25000000,
  parameter int unsigned REPEAT_CYC   = 5000000,
  parameter logic [N_BTN-1:0] REPEAT_EN = N_BTN'(1)
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_event,
  output logic [N_BTN-1:0] btn_repeat
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_channel #(
      .ACTIVE_LOW  (ACTIVE_LOW),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .HOLD_CYC    (HOLD_CYC),
      .REPEAT_CYC  (REPEAT_CYC),
      .REPEAT_EN   (REPEAT_EN[i])
    ) u_chan (
      .clk_i    (clk_clk),
      .rst_i    (reset_reset),
      .raw_i    (btn_raw[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .repeat_o (btn_repeat[i])
    );
  end

  // Press and repeat are mutually exclusive per channel, so the OR stays a single-cycle pulse.
  assign btn_event = btn_press | btn_repeat;

endmodule : btn_conditioner

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed scenarios plus random pin
// activity, every cycle compared against an event-timing reference model.
module tb_btn_conditioner;
  import btn_pkg::*;

  localparam int         N   = 3;
  localparam int         D   = 4;
  localparam int         H   = 10;
  localparam int         R   = 3;
  localparam logic [2:0] REN = 3'b001;

  logic       clk_clk = 1'b0;
  logic       reset_reset;
  logic [2:0] btn_raw;
  logic [2:0] btn_level, btn_press, btn_release, btn_event, btn_repeat;

  btn_conditioner #(
    .N_BTN       (N),
    .ACTIVE_LOW  (1'b1),
    .DEBOUNCE_CYC(D),
    .HOLD_CYC    (H),
    .REPEAT_CYC  (R),
    .REPEAT_EN   (REN)
  ) dut (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_event  (btn_event),
    .btn_repeat (btn_repeat)
  );

  always #5 clk_clk = ~clk_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: synchronised pressed-level samples, length of the current
  // run of identical samples, accepted level, and cycles since the press pulse.
  bit         m_s1[N], m_s2[N], m_stable[N];
  int         m_run[N], m_age[N];
  logic [2:0] e_level = '0, e_press = '0, e_release = '0, e_repeat = '0;

  // Observation marks for the directed scenarios.
  int first_press[N], first_release[N], press_cnt[N], rel_cnt[N], rep_cnt[N];
  int rep_with_rel;
  int rep_at[$];

  int         cd[N];
  logic [2:0] rnd_raw;
  logic       rnd_rst;
  int         c0, p0, exp_reps;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge(input logic [2:0] raw, input logic rst);
    bit was;
    bit nxt;
    for (int b = 0; b < N; b++) begin
      if (rst) begin
        m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_stable[b] = 1'b0;
        m_run[b] = 1;   m_age[b] = 0;
        e_level[b] = 1'b0; e_press[b] = 1'b0; e_release[b] = 1'b0; e_repeat[b] = 1'b0;
      end else begin
        was          = e_level[b];
        e_level[b]   = m_stable[b];
        e_press[b]   = m_stable[b] && !was;
        e_release[b] = !m_stable[b] && was;
        e_repeat[b]  = 1'b0;
        if (m_stable[b] && was) begin
          m_age[b]++;
          if (REN[b] && m_age[b] >= H && ((m_age[b] - H) % R) == 0) e_repeat[b] = 1'b1;
        end else begin
          m_age[b] = 0;
        end
        // A new level is accepted once D consecutive samples disagree with the old one.
        if (m_s2[b] != m_stable[b] && m_run[b] >= D) m_stable[b] = m_s2[b];
        nxt      = m_s1[b];
        m_run[b] = (nxt == m_s2[b]) ? ((m_run[b] < 1000) ? m_run[b] + 1 : m_run[b]) : 1;
        m_s2[b]  = nxt;
        m_s1[b]  = ~raw[b];
      end
    end
  endtask

  task automatic clear_marks();
    for (int b = 0; b < N; b++) begin
      first_press[b] = -1; first_release[b] = -1;
      press_cnt[b] = 0; rel_cnt[b] = 0; rep_cnt[b] = 0;
    end
    rep_with_rel = 0;
    rep_at.delete();
  endtask

  task automatic cycle(input logic [2:0] raw, input logic rst);
    btn_raw     = raw;
    reset_reset = rst;
    @(posedge clk_clk);
    model_edge(raw, rst);
    cyc++;
    @(negedge clk_clk);
    check("level",   btn_level,   e_level);
    check("press",   btn_press,   e_press);
    check("release", btn_release, e_release);
    check("repeat",  btn_repeat,  e_repeat);
    check("event",   btn_event,   e_press | e_repeat);
    for (int b = 0; b < N; b++) begin
      if (btn_press[b] === 1'b1) begin
        press_cnt[b]++;
        if (first_press[b] < 0) first_press[b] = cyc;
      end
      if (btn_release[b] === 1'b1) begin
        rel_cnt[b]++;
        if (first_release[b] < 0) first_release[b] = cyc;
        if (btn_repeat[b] === 1'b1) rep_with_rel++;
      end
      if (btn_repeat[b] === 1'b1) begin
        rep_cnt[b]++;
        if (b == BTN_INC) rep_at.push_back(cyc);
      end
    end
  endtask

  initial begin
    btn_raw     = 3'b111;
    reset_reset = 1'b1;
    clear_marks();

    // Reset, then idle with all buttons released.
    repeat (3) cycle(3'b111, 1'b1);
    check("reset_outputs", {btn_level, btn_press, btn_release, btn_repeat}, 12'h000);
    repeat (5) cycle(3'b111, 1'b0);

    // Clean press on inc, then keep holding for auto-repeat.
    clear_marks();
    c0 = cyc + 1;
    repeat (12) cycle(3'b110, 1'b0);
    check("press_latency", first_press[BTN_INC] - c0, D + 2);
    check("press_once", press_cnt[BTN_INC], 1);
    check("level_held", btn_level[BTN_INC], 1'b1);
    p0 = first_press[BTN_INC];
    repeat (26) cycle(3'b110, 1'b0);
    exp_reps = (cyc - p0 - H) / R + 1;
    check("repeat_count", rep_cnt[BTN_INC], exp_reps);
    check("first_repeat", (rep_at.size() > 0) ? rep_at[0] - p0 : -1, H);
    check("repeat_period", (rep_at.size() > 1) ? rep_at[1] - rep_at[0] : -1, R);

    // Release of inc.
    clear_marks();
    c0 = cyc + 1;
    repeat (10) cycle(3'b111, 1'b0);
    check("release_latency", first_release[BTN_INC] - c0, D + 2);
    check("release_once", rel_cnt[BTN_INC], 1);
    check("no_repeat_on_release", rep_with_rel, 0);
    check("level_dropped", btn_level[BTN_INC], 1'b0);

    // Glitch on mode: three cycles low is shorter than the debounce window.
    clear_marks();
    repeat (3) cycle(3'b101, 1'b0);
    repeat (10) cycle(3'b111, 1'b0);
    check("glitch_press", press_cnt[BTN_MODE], 0);
    check("glitch_release", rel_cnt[BTN_MODE], 0);
    check("glitch_level", btn_level, 3'b000);

    // Hold sel, whose auto-repeat is disabled.
    clear_marks();
    repeat (36) cycle(3'b011, 1'b0);
    check("norep_press", press_cnt[BTN_SEL], 1);
    check("norep_repeat", rep_cnt[BTN_SEL], 0);
    repeat (10) cycle(3'b111, 1'b0);

    // All buttons pressed on the same edge.
    clear_marks();
    c0 = cyc + 1;
    repeat (10) cycle(3'b000, 1'b0);
    check("simul_latency", first_press[BTN_INC] - c0, D + 2);
    check("simul_mode", first_press[BTN_MODE], first_press[BTN_INC]);
    check("simul_sel", first_press[BTN_SEL], first_press[BTN_INC]);
    repeat (10) cycle(3'b111, 1'b0);

    // Reset while inc is auto-repeating; the held button re-presses afterwards.
    clear_marks();
    repeat (20) cycle(3'b110, 1'b0);
    check("pre_reset_repeating", rep_cnt[BTN_INC] > 0, 1'b1);
    cycle(3'b110, 1'b1);
    check("reset_mid_hold", {btn_level, btn_press, btn_release, btn_repeat}, 12'h000);
    clear_marks();
    c0 = cyc + 1;
    repeat (10) cycle(3'b110, 1'b0);
    check("repress_latency", first_press[BTN_INC] - c0, D + 2);
    repeat (10) cycle(3'b111, 1'b0);

    // Random pin activity with occasional resets.
    rnd_raw = 3'b111;
    for (int b = 0; b < N; b++) cd[b] = $urandom_range(1, 14);
    for (int k = 0; k < 800; k++) begin
      for (int b = 0; b < N; b++) begin
        if (cd[b] == 0) begin
          rnd_raw[b] = ~rnd_raw[b];
          cd[b]      = $urandom_range(1, 14);
        end else begin
          cd[b]--;
        end
      end
      rnd_rst = ($urandom_range(0, 199) == 0);
      cycle(rnd_raw, rnd_rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_btn_conditioner
